// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/response bus bundle between requesting ports, arbiter and memory
interface mem_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [NUM_PORTS-1:0]        port_req_valid;
  logic [NUM_PORTS*ADDR_W-1:0] port_req_addr;
  logic [NUM_PORTS*DATA_W-1:0] port_req_data;
  logic [NUM_PORTS*2-1:0]      port_req_fcn;
  logic [NUM_PORTS*3-1:0]      port_req_typ;
  logic [NUM_PORTS-1:0]        port_req_ready;
  logic [NUM_PORTS-1:0]        port_res_valid;
  logic [DATA_W-1:0]           port_res_data;

  logic                        mem_req_valid;
  logic [ADDR_W-1:0]           mem_req_addr;
  logic [DATA_W-1:0]           mem_req_data;
  logic [1:0]                  mem_req_fcn;
  logic [2:0]                  mem_req_typ;
  logic                        mem_req_ready;
  logic                        mem_res_valid;
  logic [DATA_W-1:0]           mem_res_data;

  // arbiter side
  modport slave (
    input  port_req_valid, port_req_addr, port_req_data, port_req_fcn, port_req_typ,
    output port_req_ready, port_res_valid, port_res_data,
    output mem_req_valid, mem_req_addr, mem_req_data, mem_req_fcn, mem_req_typ,
    input  mem_req_ready, mem_res_valid, mem_res_data
  );

  // requesters plus memory side, as seen from outside the arbiter
  modport master (
    output port_req_valid, port_req_addr, port_req_data, port_req_fcn, port_req_typ,
    input  port_req_ready, port_res_valid, port_res_data,
    input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_fcn, mem_req_typ,
    output mem_req_ready, mem_res_valid, mem_res_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - multi-port memory request arbiter with in-order response routing
module mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUT   = 4,
  parameter int ARB_MODE  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mem_arbiter_if.slave             bus,
  output logic [$clog2(MAX_OUT):0] outstanding,
  output logic                     err_orphan
);
  localparam int IW = $clog2(NUM_PORTS);
  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;
  localparam logic [IW:0] NP_W = (IW+1)'(NUM_PORTS);

  typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_t;

  arb_state_t           state;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        lock_idx;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        grant;
  logic [IW-1:0]        head_tag;
  logic [IW-1:0]        base;
  logic [IW-1:0]        offset;
  logic [IW:0]          win_sum;
  logic [NUM_PORTS-1:0] valid_rot;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [IW-1:0]        tag_mem [MAX_OUT];
  logic                 locked;
  logic                 any_valid;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 orphan;

  assign locked    = (state == ARB_LOCKED);
  assign any_valid = |bus.port_req_valid;
  assign full      = (outstanding == CW'(MAX_OUT));
  assign base      = (ARB_MODE == 0) ? '0 : rr_ptr;
  assign valid_rot = NUM_PORTS'({bus.port_req_valid, bus.port_req_valid} >> base);

  // Winner is the first valid port at or after base, wrapping past the top port
  always_comb begin
    offset = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (valid_rot[k]) offset = IW'(k);
    end
    win_sum = {1'b0, base} + {1'b0, offset};
    if (win_sum >= NP_W) win_sum = win_sum - NP_W;
    win_idx = win_sum[IW-1:0];
  end

  assign grant             = locked ? lock_idx : win_idx;
  assign head_tag          = tag_mem[rd_ptr];
  assign bus.mem_req_valid = (any_valid | locked) & ~full;
  assign push              = bus.mem_req_valid & bus.mem_req_ready;
  assign pop               = bus.mem_res_valid & (outstanding != '0);
  assign orphan            = bus.mem_res_valid & (outstanding == '0);
  assign bus.port_res_data = bus.mem_res_data;

  // Mux the granted port's fields downstream and steer the response to the head tag
  always_comb begin
    bus.mem_req_addr   = '0;
    bus.mem_req_data   = '0;
    bus.mem_req_fcn    = '0;
    bus.mem_req_typ    = '0;
    bus.port_req_ready = '0;
    bus.port_res_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant == IW'(i)) begin
        bus.mem_req_addr      = bus.port_req_addr[i*ADDR_W +: ADDR_W];
        bus.mem_req_data      = bus.port_req_data[i*DATA_W +: DATA_W];
        bus.mem_req_fcn       = bus.port_req_fcn[i*2 +: 2];
        bus.mem_req_typ       = bus.port_req_typ[i*3 +: 3];
        bus.port_req_ready[i] = push;
      end
      if (head_tag == IW'(i)) bus.port_res_valid[i] = pop;
    end
  end

  // Grant lock, round-robin pointer, tag FIFO pointers, occupancy and orphan flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_OPEN;
      lock_idx    <= '0;
      rr_ptr      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      err_orphan  <= 1'b0;
    end else begin
      if (bus.mem_req_valid && !bus.mem_req_ready) begin
        state    <= ARB_LOCKED;
        lock_idx <= grant;
      end else begin
        state <= ARB_OPEN;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        rr_ptr <= (grant == IW'(NUM_PORTS - 1)) ? '0 : grant + IW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop) outstanding <= outstanding + CW'(1);
      else if (pop && !push) outstanding <= outstanding - CW'(1);
      if (orphan) err_orphan <= 1'b1;
    end
  end

  // Tag storage is only read between rd_ptr and wr_ptr, so it carries no reset
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant;
  end
endmodule
